// File: rtl/aes_round_engine.sv
`timescale 1ns / 1ps
// aes_round_engine: iterative AES encryptor with a lane-parallel SubBytes
// stage, a ShiftRows/MixColumns/AddRoundKey stage and registered 128-bit state.
// Ports: clk, rst_n (async low), in_valid/in_ready/in_data (plaintext),
// key_idx/round_key (external key schedule), out_valid/out_ready/out_data
// (ciphertext), busy, and abort when AES_ABORT_EN is defined.
module aes_round_engine #(
    parameter int NUM_ROUNDS = 10,
    parameter int SBOX_LANES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef AES_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   key_idx,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (!(NUM_ROUNDS == 10 || NUM_ROUNDS == 12 || NUM_ROUNDS == 14)) begin : gBadRounds
        $error("aes_round_engine: NUM_ROUNDS must be 10, 12 or 14");
    end
    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
          SBOX_LANES == 8 || SBOX_LANES == 16)) begin : gBadLanes
        $error("aes_round_engine: SBOX_LANES must be 1, 2, 4, 8 or 16");
    end

    localparam int SUB_CYCLES = 16 / SBOX_LANES;
    localparam logic [3:0] LAST_LANE = 4'(SUB_CYCLES - 1);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, SUB, XFORM, DONE} engineStateT;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        // ~b * 8 is the bit offset of entry b counted from the LSB.
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // Bit offset of byte i (byte 0 is the most significant byte).
    function automatic logic [6:0] bytePos(input int i);
        return 7'(8 * (15 - i));
    endfunction

    function automatic logic [127:0] subLanes(input logic [127:0] s,
                                              input logic [3:0] lane);
        logic [127:0] r;
        int bi;
        r = s;
        for (int j = 0; j < SBOX_LANES; j++) begin
            bi = int'(lane) * SBOX_LANES + j;
            r[bytePos(bi) +: 8] = sbox(s[bytePos(bi) +: 8]);
        end
        return r;
    endfunction

    function automatic logic [127:0] shiftRows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[bytePos(4 * c + row) +: 8] =
                    s[bytePos(4 * ((c + row) % 4) + row) +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mixColumns(input logic [127:0] s);
        logic [127:0] r;
        logic [31:0] col;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            col = s[7'(32 * (3 - c)) +: 32];
            a0 = col[31:24];
            a1 = col[23:16];
            a2 = col[15:8];
            a3 = col[7:0];
            r[7'(32 * (3 - c)) +: 32] = {
                xtime(a0) ^ mul3(a1) ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ mul3(a2) ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ mul3(a3),
                mul3(a0) ^ a1 ^ a2 ^ xtime(a3)
            };
        end
        return r;
    endfunction

    engineStateT  fsmQ;
    logic [127:0] stateQ;
    logic [3:0]   roundQ;
    logic [3:0]   laneQ;
    logic         inReadyQ;
    logic         outValidQ;
    logic         busyQ;

    logic [127:0] subNext;
    logic [127:0] shifted;
    logic [127:0] mixed;
    logic [127:0] xformNext;

    assign subNext   = subLanes(stateQ, laneQ);
    assign shifted   = shiftRows(stateQ);
    // The last round leaves out MixColumns.
    assign mixed     = (roundQ == LAST_ROUND) ? shifted : mixColumns(shifted);
    assign xformNext = mixed ^ round_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsmQ      <= IDLE;
            stateQ    <= '0;
            roundQ    <= '0;
            laneQ     <= '0;
            inReadyQ  <= 1'b1;
            outValidQ <= 1'b0;
            busyQ     <= 1'b0;
        end else begin
            unique case (fsmQ)
                IDLE: begin
                    if (in_valid) begin
                        stateQ   <= in_data ^ round_key;
                        roundQ   <= 4'd1;
                        laneQ    <= '0;
                        fsmQ     <= SUB;
                        inReadyQ <= 1'b0;
                        busyQ    <= 1'b1;
                    end
                end
                SUB: begin
                    stateQ <= subNext;
                    laneQ  <= laneQ + 4'd1;
                    if (laneQ == LAST_LANE) begin
                        fsmQ <= XFORM;
                    end
                end
                XFORM: begin
                    stateQ <= xformNext;
                    laneQ  <= '0;
                    if (roundQ == LAST_ROUND) begin
                        fsmQ      <= DONE;
                        outValidQ <= 1'b1;
                    end else begin
                        roundQ <= roundQ + 4'd1;
                        fsmQ   <= SUB;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsmQ      <= IDLE;
                        roundQ    <= '0;
                        outValidQ <= 1'b0;
                        inReadyQ  <= 1'b1;
                        busyQ     <= 1'b0;
                    end
                end
                default: fsmQ <= IDLE;
            endcase
`ifdef AES_ABORT_EN
            // Placed last so it overrides every case-branch update.
            if (abort && fsmQ != IDLE) begin
                fsmQ      <= IDLE;
                stateQ    <= '0;
                roundQ    <= '0;
                laneQ     <= '0;
                outValidQ <= 1'b0;
                inReadyQ  <= 1'b1;
                busyQ     <= 1'b0;
            end
`endif
        end
    end

    assign in_ready  = inReadyQ;
    assign out_valid = outValidQ;
    assign busy      = busyQ;
    assign key_idx   = roundQ;
    assign out_data  = stateQ;

endmodule

// File: tb/tb_aes_round_engine.sv
`timescale 1ns / 1ps
// tb_aes_round_engine: directed FIPS-197 vectors on three parameter sets,
// backpressure, mid-run reset and (with AES_ABORT_EN) abort.
module tb_aes_round_engine;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]        inValid;
    logic [2:0]        inReady;
    logic [2:0]        outValid;
    logic [2:0]        outReady;
    logic [2:0]        busy;
    logic [2:0][127:0] inData;
    logic [2:0][127:0] roundKey;
    logic [2:0][127:0] outData;
    logic [2:0][3:0]   keyIdx;
`ifdef AES_ABORT_EN
    logic [2:0]        abortIn;
`endif

    logic [127:0] rk [3][16];
    logic [7:0]   sb [256];
    logic [127:0] expQ [$];
    int total = 0;
    int bad = 0;

    assign roundKey[0] = rk[0][keyIdx[0]];
    assign roundKey[1] = rk[1][keyIdx[1]];
    assign roundKey[2] = rk[2][keyIdx[2]];

    aes_round_engine #(.NUM_ROUNDS(10), .SBOX_LANES(16)) u0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0]),
        .key_idx(keyIdx[0]), .round_key(roundKey[0]),
        .out_valid(outValid[0]), .out_ready(outReady[0]),
        .out_data(outData[0]), .busy(busy[0])
`ifdef AES_ABORT_EN
        , .abort(abortIn[0])
`endif
    );

    aes_round_engine #(.NUM_ROUNDS(10), .SBOX_LANES(4)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]),
        .key_idx(keyIdx[1]), .round_key(roundKey[1]),
        .out_valid(outValid[1]), .out_ready(outReady[1]),
        .out_data(outData[1]), .busy(busy[1])
`ifdef AES_ABORT_EN
        , .abort(abortIn[1])
`endif
    );

    aes_round_engine #(.NUM_ROUNDS(14), .SBOX_LANES(16)) u2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid[2]), .in_ready(inReady[2]), .in_data(inData[2]),
        .key_idx(keyIdx[2]), .round_key(roundKey[2]),
        .out_valid(outValid[2]), .out_ready(outReady[2]),
        .out_data(outData[2]), .busy(busy[2])
`ifdef AES_ABORT_EN
        , .abort(abortIn[2])
`endif
    );

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_C3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] JUNK  = 128'hdeadbeef0123456789abcdeffedcba98;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] calcSbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Key schedule; key is left-aligned in 256 bits, nk in 32-bit words.
    task automatic loadKey(input int d, input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0] rc;
        int nw;
        nw = 4 * (nk + 7);
        rc = 8'h01;
        for (int i = 0; i < nw; i++) begin
            if (i < nk) begin
                w[i] = key[8'(255 - 32 * i) -: 32];
            end else begin
                t = w[i - 1];
                if (i % nk == 0) begin
                    t = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                    rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subWord(t);
                end
                w[i] = w[i - nk] ^ t;
            end
        end
        for (int r = 0; r < nk + 7; r++) begin
            rk[d][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        end
    endtask

    task automatic sendBlock(input int d, input logic [127:0] pt,
                             input bit push, input logic [127:0] ct,
                             input string tag);
        @(negedge clk);
        check({tag, "_in_ready_idle"}, 128'(inReady[d]), 128'd1);
        inData[d] = pt;
        inValid[d] = 1'b1;
        if (push) expQ.push_back(ct);
        @(posedge clk);
        #1;
        inValid[d] = 1'b0;
        check({tag, "_busy_after_accept"}, 128'(busy[d]), 128'd1);
    endtask

    // Count edges from the accept edge to out_valid, tracking key_idx.
    task automatic waitOut(input int d, input int lat, input int c,
                           input string tag);
        int n;
        int idxErr;
        logic [127:0] exp;
        n = 0;
        idxErr = 0;
        while (outValid[d] !== 1'b1 && n < 400) begin
            if (int'(keyIdx[d]) != n / (c + 1) + 1) idxErr++;
            if (inReady[d] !== 1'b0) idxErr++;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, 128'(n), 128'(lat));
        check({tag, "_keyidx_trace"}, 128'(idxErr), 128'd0);
        exp = 'x;
        if (expQ.size() > 0) exp = expQ.pop_front();
        check({tag, "_data"}, outData[d], exp);
    endtask

    task automatic finishOut(input int d, input string tag);
        @(negedge clk);
        outReady[d] = 1'b1;
        @(posedge clk);
        #1;
        outReady[d] = 1'b0;
        check({tag, "_in_ready_after"}, 128'(inReady[d]), 128'd1);
        check({tag, "_out_valid_after"}, 128'(outValid[d]), 128'd0);
        check({tag, "_idle_key_idx"}, 128'(keyIdx[d]), 128'd0);
    endtask

    task automatic waitKeyIdx(input int d, input logic [3:0] k, input string tag);
        int n;
        n = 0;
        while (keyIdx[d] !== k && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_reached_round"}, 128'(keyIdx[d]), 128'(k));
    endtask

    initial begin
        rst_n = 1'b0;
        inValid = '0;
        outReady = '0;
        inData = '0;
`ifdef AES_ABORT_EN
        abortIn = '0;
`endif
        for (int i = 0; i < 256; i++) sb[i] = calcSbox(8'(i));
        for (int d = 0; d < 3; d++) begin
            for (int r = 0; r < 16; r++) rk[d][r] = '0;
        end
        loadKey(0, {KEY_B, 128'h0}, 4);
        loadKey(1, {KEY_C1, 128'h0}, 4);
        loadKey(2, KEY_C3, 8);

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(inReady[0]), 128'd1);
        check("rst_out_valid", 128'(outValid[0]), 128'd0);
        check("rst_busy", 128'(busy[0]), 128'd0);
        check("rst_key_idx", 128'(keyIdx[0]), 128'd0);
        check("rst_out_data", outData[0], 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        sendBlock(0, PT_B, 1'b1, CT_B, "appB");
        waitOut(0, 20, 1, "appB");
        finishOut(0, "appB");

        sendBlock(1, PT_C, 1'b1, CT_C1, "c1_l4");
        waitOut(1, 50, 4, "c1_l4");
        check("c1_l4_done_key_idx", 128'(keyIdx[1]), 128'd10);
        finishOut(1, "c1_l4");

        sendBlock(2, PT_C, 1'b1, CT_C3, "c3_r14");
        waitOut(2, 28, 1, "c3_r14");
        finishOut(2, "c3_r14");

        // Backpressure, with the key schedule switched while parked.
        sendBlock(0, PT_B, 1'b1, CT_B, "bp1");
        waitOut(0, 20, 1, "bp1");
        loadKey(0, {KEY_C1, 128'h0}, 4);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            inValid[0] = (i % 2 == 0);
            inData[0] = JUNK;
            @(posedge clk);
            #1;
            check("bp_hold_data", outData[0], CT_B);
            check("bp_hold_flags", {125'd0, outValid[0], inReady[0], busy[0]},
                  128'b101);
        end
        @(negedge clk);
        outReady[0] = 1'b1;
        inValid[0] = 1'b1;
        @(posedge clk);
        #1;
        outReady[0] = 1'b0;
        check("bp_release_in_ready", 128'(inReady[0]), 128'd1);
        check("bp_release_out_valid", 128'(outValid[0]), 128'd0);
        inData[0] = PT_C;
        expQ.push_back(CT_C1);
        @(posedge clk);
        #1;
        inValid[0] = 1'b0;
        check("bp2_busy", 128'(busy[0]), 128'd1);
        waitOut(0, 20, 1, "bp2");
        finishOut(0, "bp2");

        // Reset in round 5.
        loadKey(0, {KEY_B, 128'h0}, 4);
        sendBlock(0, PT_B, 1'b0, '0, "rstmid");
        waitKeyIdx(0, 4'd5, "rstmid");
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_in_ready", 128'(inReady[0]), 128'd1);
        check("rstmid_out_valid", 128'(outValid[0]), 128'd0);
        check("rstmid_busy", 128'(busy[0]), 128'd0);
        check("rstmid_key_idx", 128'(keyIdx[0]), 128'd0);
        check("rstmid_out_data", outData[0], 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sendBlock(0, PT_B, 1'b1, CT_B, "rerun");
        waitOut(0, 20, 1, "rerun");
        finishOut(0, "rerun");

`ifdef AES_ABORT_EN
        begin
            int seen;
            @(negedge clk);
            abortIn[0] = 1'b1;
            @(posedge clk);
            #1;
            abortIn[0] = 1'b0;
            check("abort_idle_in_ready", 128'(inReady[0]), 128'd1);
            check("abort_idle_data_kept", outData[0], CT_B);
            sendBlock(0, PT_B, 1'b0, '0, "abort");
            waitKeyIdx(0, 4'd3, "abort");
            @(negedge clk);
            abortIn[0] = 1'b1;
            @(posedge clk);
            #1;
            abortIn[0] = 1'b0;
            check("abort_in_ready", 128'(inReady[0]), 128'd1);
            check("abort_busy", 128'(busy[0]), 128'd0);
            check("abort_key_idx", 128'(keyIdx[0]), 128'd0);
            check("abort_out_data", outData[0], 128'd0);
            seen = 0;
            for (int i = 0; i < 30; i++) begin
                if (outValid[0] !== 1'b0) seen++;
                @(posedge clk);
                #1;
            end
            check("abort_no_out_valid", 128'(seen), 128'd0);
            sendBlock(0, PT_B, 1'b1, CT_B, "after_abort");
            waitOut(0, 20, 1, "after_abort");
            finishOut(0, "after_abort");
        end
`endif

        check("scoreboard_empty", 128'(expQ.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_round_engine.md
Name: aes_round_engine

Overview:
- Iterative AES encryption core built on the existing final-round datapath: SubBytes -> ShiftRows -> (MixColumns) -> AddRoundKey.
- Runs the initial AddRoundKey, NUM_ROUNDS-1 full rounds and one final round (no MixColumns) on a single registered 128-bit state.
- Valid/ready handshakes on input and output; round keys are fetched from an external key schedule through a round-index port.
- S-box lane count is parametrised to trade area against latency.

Parameters:
- NUM_ROUNDS, 10, total rounds; legal values 10/12/14 (AES-128/192/256).
- SBOX_LANES, 16, bytes substituted per cycle; legal values 1/2/4/8/16. C = 16/SBOX_LANES SubBytes cycles per round.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data valid.
- in_ready  out  1  engine can accept a block.
- in_data  in  128  plaintext; byte 0 = in_data[127:120]; column-major per FIPS-197.
- key_idx  out  4  index of the round key required this cycle.
- round_key  in  128  key for key_idx; combinational from the schedule, same byte order.
- out_valid  out  1  out_data holds ciphertext.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  128  ciphertext (registered state).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State -> IDLE; state register = 0; round counter = 0; lane counter = 0.
  - Outputs: in_ready=1, out_valid=0, busy=0, key_idx=0, out_data=0.
- FSM states: IDLE, SUB, XFORM, DONE.
- IDLE:
  - in_ready=1, key_idx=0.
  - On in_valid&&in_ready: state <= in_data ^ round_key; round <= 1; lane <= 0; go to SUB.
- SUB:
  - Each cycle, bytes lane*L .. lane*L+L-1 (L = SBOX_LANES) of state are replaced by their S-box values; lane increments.
  - After C cycles (lane == C-1), go to XFORM.
  - key_idx = round.
- XFORM, one cycle, key_idx = round:
  - state <= AddRoundKey(MixColumns(ShiftRows(state)), round_key) when round < NUM_ROUNDS.
  - When round == NUM_ROUNDS, MixColumns is skipped.
  - If round == NUM_ROUNDS, go to DONE; otherwise round++, lane <= 0, go to SUB.
- DONE:
  - out_valid=1; out_data stable; in_ready=0.
  - On out_ready, go to IDLE.
  - out_valid holds indefinitely under backpressure.
- round_key is sampled only on the accepting edge and on XFORM edges; its value is ignored in SUB and DONE.
- Latency: out_valid rises on the NUM_ROUNDS*(C+1)-th rising edge after the accepting edge.
  - Defaults: 20 cycles.
  - SBOX_LANES=4: 50 cycles.
- Throughput: one block in flight. The next block can be accepted at the earliest in the cycle after the output handshake, since in_ready only rises in IDLE.
- Handshake rules:
  - out_ready while out_valid=0 is ignored.
  - in_valid while in_ready=0 is ignored and does not queue.
- Reset mid-operation: the block is discarded, all registers clear immediately, and no out_valid is produced for it.
- Width rules:
  - All byte arithmetic is GF(2^8) with polynomial 0x11B.
  - The round counter is 4 bits.
  - Illegal parameter values stop elaboration with an error.

Optional Feature:
- Macro: AES_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - abort=1 in SUB, XFORM or DONE forces IDLE on the next edge and clears state, round and lane. out_valid is 0 from that edge.
  - abort in IDLE has no effect.
  - abort takes priority over out_ready in DONE.
- When not defined: the abort port does not exist and the FSM has no abort path.

Test Plan:
- FIPS-197 App. B, defaults: in_data 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> out_data 3925841d02dc09fbdc118597196a0b32; out_valid rises exactly 20 cycles after acceptance.
- FIPS-197 C.1, SBOX_LANES=4: in 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> 69c4e0d86a7b0430d8cdb78070b4c55a after 50 cycles; key_idx steps 0..10.
- FIPS-197 C.3, NUM_ROUNDS=14: same plaintext, key 00..1f -> 8ea2b7ca516745bfeafc49904b496089 after 28 cycles.
- Backpressure: hold out_ready=0 for 7 cycles after out_valid -> out_data stable, in_ready=0, in_valid pulses ignored. Release -> IDLE next cycle, then accept a second vector back-to-back and check the correct result.
- Reset mid-op: drop rst_n in round 5 -> all outputs take their reset values immediately. Re-run App. B -> correct result.
- AES_ABORT_EN: pulse abort in round 3 -> IDLE next edge, no out_valid. The next block completes correctly.
